// File: rtl/booth_product_unloader.sv
// booth_product_unloader: drain side of the Booth multiplier datapath.
// Holds up to two completed products in a 2-entry circular buffer and
// sends each one as two words, low half first, over a valid/ready port.
// All state changes on the falling clock edge; reset is asynchronous.
//
// Handshake: a word transfers at a falling edge where word_valid and
// word_ready are both 1. While word_valid=1 and word_ready=0, word_out and
// word_last hold steady. word_ready with word_valid=0 does nothing.
module booth_product_unloader #(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2*DATA_W-1:0]   prod_in,
    input  logic                  prod_ld,
    output logic                  prod_full,
    output logic [DATA_W-1:0]     word_out,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  word_last,
    output logic                  ovf,
    input  logic                  ovf_clr
);

    localparam int PW = 2 * DATA_W;

    logic [PW-1:0] mem_q [2];
    logic [PW-1:0] mem_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic          half_q, half_d;
    logic          ovf_q, ovf_d;
    logic [1:0]    count_q, count_d;

    logic          pop_word;
    logic          pop_last;
    logic          room;
    logic          do_load;
    logic          do_drop;

    // Output decode straight from registered state.
    always_comb begin
        word_valid = (count_q != 2'd0);
        word_last  = word_valid & half_q;
        prod_full  = (count_q == 2'd2);
        ovf        = ovf_q;
        if (half_q) begin
            word_out = mem_q[rd_ptr_q][PW-1:DATA_W];
        end else begin
            word_out = mem_q[rd_ptr_q][DATA_W-1:0];
        end
    end

    // Next-state: transfer, load (room may come from a same-edge last-word pop), overflow.
    always_comb begin
        pop_word = (count_q != 2'd0) & word_ready;
        pop_last = pop_word & half_q;
        // When full, the write pointer equals the read pointer, so a load on
        // a last-word pop overwrites exactly the entry being retired.
        room     = (count_q != 2'd2) | pop_last;
        do_load  = prod_ld & room;
        do_drop  = prod_ld & ~room;

        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        half_d   = half_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (do_load) begin
            mem_d[wr_ptr_q] = prod_in;
            wr_ptr_d        = ~wr_ptr_q;
        end

        if (pop_word) begin
            if (half_q) begin
                half_d   = 1'b0;
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                half_d   = 1'b1;
            end
        end

        case ({do_load, pop_last})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // A dropped load on the same edge as a clear leaves the flag set.
        if (do_drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // State registers, falling edge, asynchronous active-low reset.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            half_q   <= 1'b0;
            count_q  <= 2'd0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            half_q   <= half_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_booth_product_unloader.sv
// Directed bench for booth_product_unloader. Inputs change and outputs are
// sampled 1 ns after each falling edge, well away from the next active edge.
module tb_booth_product_unloader;

    logic        clk;
    logic        rst_n;
    logic [31:0] prod_in;
    logic        prod_ld;
    logic        prod_full;
    logic [15:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic        word_last;
    logic        ovf;
    logic        ovf_clr;

    int checks = 0;
    int errors = 0;

    booth_product_unloader #(.DATA_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prod_in    (prod_in),
        .prod_ld    (prod_ld),
        .prod_full  (prod_full),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_last  (word_last),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    // Clock: falling edges at 5, 15, 25 ns ...
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks the word currently presented.
    task automatic check_word(input string tag, input logic [15:0] w, input logic last);
        check({tag, "_valid"}, 32'(word_valid), 32'd1);
        check({tag, "_word"}, 32'(word_out), 32'(w));
        check({tag, "_last"}, 32'(word_last), 32'(last));
    endtask

    logic [15:0] s_hi [8];
    logic [15:0] s_lo [8];

    initial begin
        s_hi = '{16'h0101, 16'h0202, 16'h0303, 16'h0404,
                 16'hA5A5, 16'h5A5A, 16'hFFFF, 16'h0000};
        s_lo = '{16'h1010, 16'h2020, 16'h3030, 16'h4040,
                 16'h1234, 16'h8765, 16'h0000, 16'hFFFF};

        rst_n      = 1'b0;
        prod_in    = 32'h0;
        prod_ld    = 1'b0;
        word_ready = 1'b0;
        ovf_clr    = 1'b0;

        // ---- Reset and single product ----
        tick();
        tick();
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_last",  32'(word_last),  32'd0);
        check("rst_full",  32'(prod_full),  32'd0);
        check("rst_ovf",   32'(ovf),        32'd0);
        check("rst_word",  32'(word_out),   32'd0);
        rst_n = 1'b1;
        prod_in = 32'hDEAD_BEEF; prod_ld = 1'b1; word_ready = 1'b1;
        tick();
        prod_ld = 1'b0;
        check_word("single_lo", 16'hBEEF, 1'b0);
        tick();
        check_word("single_hi", 16'hDEAD, 1'b1);
        tick();
        check("single_done", 32'(word_valid), 32'd0);

        // ---- Backpressure ----
        word_ready = 1'b0;
        prod_in = 32'h1234_5678; prod_ld = 1'b1;
        tick();
        prod_ld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_word("bp_hold", 16'h5678, 1'b0);
            tick();
        end
        word_ready = 1'b1;
        check_word("bp_lo", 16'h5678, 1'b0);
        tick();
        check_word("bp_hi", 16'h1234, 1'b1);
        tick();
        check("bp_done", 32'(word_valid), 32'd0);
        word_ready = 1'b0;

        // ---- Fill and overflow ----
        prod_in = 32'h0000_0001; prod_ld = 1'b1;
        tick();
        check("fill1_full", 32'(prod_full), 32'd0);
        prod_in = 32'h0000_0002;
        tick();
        check("fill2_full", 32'(prod_full), 32'd1);
        check("fill2_ovf",  32'(ovf),       32'd0);
        prod_in = 32'hFFFF_FFFF;
        tick();
        prod_ld = 1'b0;
        check("drop_ovf",  32'(ovf),       32'd1);
        check("drop_full", 32'(prod_full), 32'd1);
        check_word("drop_head", 16'h0001, 1'b0);
        word_ready = 1'b1;
        tick();
        check_word("drain_1hi", 16'h0000, 1'b1);
        tick();
        check_word("drain_2lo", 16'h0002, 1'b0);
        check("drain_full", 32'(prod_full), 32'd0);
        tick();
        check_word("drain_2hi", 16'h0000, 1'b1);
        tick();
        check("drain_done", 32'(word_valid), 32'd0);
        check("ovf_sticky", 32'(ovf), 32'd1);
        word_ready = 1'b0;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(ovf), 32'd0);

        // ---- Set wins over clear; load on last-word pop when full ----
        prod_in = 32'h1111_2222; prod_ld = 1'b1;
        tick();
        prod_in = 32'h3333_4444;
        tick();
        prod_in = 32'h9999_9999; ovf_clr = 1'b1;
        tick();
        prod_ld = 1'b0;
        check("setwins_ovf", 32'(ovf), 32'd1);
        check_word("setwins_head", 16'h2222, 1'b0);
        tick();
        ovf_clr = 1'b0;
        check("clr_ovf", 32'(ovf), 32'd0);
        word_ready = 1'b1;
        tick();
        check_word("full_hi", 16'h1111, 1'b1);
        check("full_before", 32'(prod_full), 32'd1);
        prod_in = 32'hAAAA_5555; prod_ld = 1'b1;
        tick();
        prod_ld = 1'b0;
        check("popld_full", 32'(prod_full), 32'd1);
        check("popld_ovf",  32'(ovf),       32'd0);
        check_word("popld_2lo", 16'h4444, 1'b0);
        tick();
        check_word("popld_2hi", 16'h3333, 1'b1);
        tick();
        check_word("popld_3lo", 16'h5555, 1'b0);
        check("popld_notfull", 32'(prod_full), 32'd0);
        tick();
        check_word("popld_3hi", 16'hAAAA, 1'b1);
        tick();
        check("popld_done", 32'(word_valid), 32'd0);

        // ---- Reset mid-product ----
        prod_in = 32'h1357_9BDF; prod_ld = 1'b1;
        tick();
        prod_ld = 1'b0;
        check_word("mid_lo", 16'h9BDF, 1'b0);
        tick();
        check_word("mid_hi", 16'h1357, 1'b1);
        rst_n = 1'b0;
        word_ready = 1'b0;
        #1;
        check("midrst_valid", 32'(word_valid), 32'd0);
        check("midrst_last",  32'(word_last),  32'd0);
        check("midrst_word",  32'(word_out),   32'd0);
        tick();
        rst_n = 1'b1;
        prod_in = 32'hCAFE_F00D; prod_ld = 1'b1; word_ready = 1'b1;
        tick();
        prod_ld = 1'b0;
        check_word("post_lo", 16'hF00D, 1'b0);
        tick();
        check_word("post_hi", 16'hCAFE, 1'b1);
        tick();
        check("post_done", 32'(word_valid), 32'd0);

        // ---- Back-to-back streaming ----
        for (int i = 0; i < 8; i++) begin
            prod_in = {s_hi[i], s_lo[i]}; prod_ld = 1'b1;
            tick();
            prod_ld = 1'b0;
            check_word("stream_lo", s_lo[i], 1'b0);
            check("stream_full", 32'(prod_full), 32'd0);
            tick();
            check_word("stream_hi", s_hi[i], 1'b1);
        end
        tick();
        check("stream_done", 32'(word_valid), 32'd0);
        check("stream_ovf",  32'(ovf),        32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
